// File: rtl/ucode_ifetch_if.sv
// Program-ROM read bus between the ucode fetch sequencer (master) and program memory (slave).
// rom_rd/rom_addr form the request; rom_valid strobes rom_data back.
interface ucode_ifetch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [7:0]        rom_data;
  logic              rom_valid;

  modport master (
    output rom_addr,
    output rom_rd,
    input  rom_data,
    input  rom_valid
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    output rom_data,
    output rom_valid
  );
endinterface

// File: rtl/ucode_ifetch.sv
// Ucode instruction fetch sequencer: fetches opcode (+ optional operand) from ROM, holds it for
// execution, then advances or jumps the PC. Define IFETCH_HALT_EN to make opcode 8'hFF halt fetch.
module ucode_ifetch #(
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  ucode_ifetch_if.master    rom,
  output logic [7:0]        opcode,
  output logic              opcode_valid,
  output logic [7:0]        operand,
  output logic              operand_valid,
  input  logic              needs_operand,
  input  logic              jump_operation,
  input  logic              jump_condition,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH_OP,
    WAIT_OP,
    DECODE,
    FETCH_ARG,
    WAIT_ARG,
    EXECUTE
`ifdef IFETCH_HALT_EN
    , HALT
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic              rom_rd_reg, rom_rd_next;
  logic [7:0]        opcode_reg, opcode_next;
  logic [7:0]        operand_reg, operand_next;
  logic              opcode_valid_reg, opcode_valid_next;
  logic              operand_valid_reg, operand_valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= FETCH_OP;
      pc_reg            <= RESET_VECTOR;
      rom_addr_reg      <= RESET_VECTOR;
      rom_rd_reg        <= 1'b0;
      opcode_reg        <= 8'h00;
      operand_reg       <= 8'h00;
      opcode_valid_reg  <= 1'b0;
      operand_valid_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      rom_addr_reg      <= rom_addr_next;
      rom_rd_reg        <= rom_rd_next;
      opcode_reg        <= opcode_next;
      operand_reg       <= operand_next;
      opcode_valid_reg  <= opcode_valid_next;
      operand_valid_reg <= operand_valid_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    rom_addr_next      = rom_addr_reg;
    rom_rd_next        = rom_rd_reg;
    opcode_next        = opcode_reg;
    operand_next       = operand_reg;
    opcode_valid_next  = opcode_valid_reg;
    operand_valid_next = operand_valid_reg;

    case (state_reg)
      FETCH_OP: begin
        rom_addr_next      = pc_reg;
        rom_rd_next        = 1'b1;
        opcode_valid_next  = 1'b0;
        operand_valid_next = 1'b0;
        state_next         = WAIT_OP;
      end
      // rom_valid is only honoured in the wait states, so strays elsewhere are dropped.
      WAIT_OP: begin
        if (rom.rom_valid) begin
          opcode_next       = rom.rom_data;
          opcode_valid_next = 1'b1;
          rom_rd_next       = 1'b0;
          state_next        = DECODE;
        end
      end
      DECODE: begin
`ifdef IFETCH_HALT_EN
        if (opcode_reg == 8'hFF) begin
          state_next = HALT;
        end else
`endif
        if (needs_operand) begin
          state_next = FETCH_ARG;
        end else begin
          state_next = EXECUTE;
        end
      end
      FETCH_ARG: begin
        rom_addr_next = pc_reg + ADDR_W'(1);
        rom_rd_next   = 1'b1;
        state_next    = WAIT_ARG;
      end
      WAIT_ARG: begin
        if (rom.rom_valid) begin
          operand_next       = rom.rom_data;
          operand_valid_next = 1'b1;
          rom_rd_next        = 1'b0;
          state_next         = EXECUTE;
        end
      end
      // A jump without a fetched operand deliberately reuses the stale operand register.
      EXECUTE: begin
        if (exec_done) begin
          if (jump_operation && jump_condition) begin
            pc_next = ADDR_W'(operand_reg);
          end else begin
            pc_next = pc_reg + ADDR_W'(1) + ADDR_W'(operand_valid_reg);
          end
          state_next = FETCH_OP;
        end
      end
`ifdef IFETCH_HALT_EN
      HALT: begin
        state_next = HALT;
      end
`endif
      default: begin
        state_next = FETCH_OP;
      end
    endcase
  end

  assign rom.rom_addr  = rom_addr_reg;
  assign rom.rom_rd    = rom_rd_reg;
  assign opcode        = opcode_reg;
  assign opcode_valid  = opcode_valid_reg;
  assign operand       = operand_reg;
  assign operand_valid = operand_valid_reg;
  assign pc            = pc_reg;

`ifdef IFETCH_HALT_EN
  assign halted = (state_reg == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_ifetch.sv
// Randomized bench for ucode_ifetch: reactive ROM and decoder/core models drive the DUT, an
// instruction-level reference model fills a queue that a separate monitor checks against.
`timescale 1ns/1ps
module tb_ucode_ifetch;
  localparam int         ADDR_W = 8;
  localparam logic [7:0] RV     = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] opcode, operand, pc;
  logic       opcode_valid, operand_valid, halted;
  logic       needs_operand;
  logic       jump_operation = 1'b0, jump_condition = 1'b0, exec_done = 1'b0;

  ucode_ifetch_if #(.ADDR_W(ADDR_W)) rom ();

  ucode_ifetch #(.ADDR_W(ADDR_W), .RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom            (rom),
    .opcode         (opcode),
    .opcode_valid   (opcode_valid),
    .operand        (operand),
    .operand_valid  (operand_valid),
    .needs_operand  (needs_operand),
    .jump_operation (jump_operation),
    .jump_condition (jump_condition),
    .exec_done      (exec_done),
    .pc             (pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] operand;
    bit         has;
  } rec_t;

  logic [7:0] mem [256];
  bit         needs_tbl [256];
  rec_t       exp_q [$];
  rec_t       m_rec;
  logic [7:0] m_last_operand;
  bit [1:0]   force_q [$];
  int         checks = 0;
  int         failures = 0;
  int         n_instr = 0;

  assign needs_operand = needs_tbl[opcode];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected instruction at address p, straight from the ROM image and the opcode-length table.
  function automatic rec_t mk_rec(input logic [7:0] p);
    rec_t       r;
    logic [7:0] p1;
    p1       = p + 8'd1;
    r.pc     = p;
    r.opcode = mem[p];
    r.has    = needs_tbl[r.opcode];
    if (r.has) begin
      r.operand      = mem[p1];
      m_last_operand = r.operand;
    end else begin
      r.operand = m_last_operand;
    end
    return r;
  endfunction

  task automatic restart_model();
    exp_q.delete();
    m_last_operand = 8'h00;
    m_rec = mk_rec(RV);
    exp_q.push_back(m_rec);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, RV);
    check({tag, "_rom_addr"}, rom.rom_addr, RV);
    check({tag, "_rom_rd"}, rom.rom_rd, 0);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_operand"}, operand, 0);
    check({tag, "_opcode_valid"}, opcode_valid, 0);
    check({tag, "_operand_valid"}, operand_valid, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  task automatic wait_instr(input int target);
    int cyc;
    cyc = 0;
    while (n_instr < target && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (n_instr < target) begin
      checks++;
      failures++;
      $display("FAIL instr_timeout actual=%0d required=%0d", n_instr, target);
    end
  endtask

  // Program ROM: random 0..3 wait states per request, plus stray strobes while idle.
  initial begin : rom_model
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    rom.rom_valid = 1'b0;
    rom.rom_data  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || !rom.rom_rd) begin
        busy = 1'b0;
        rom.rom_valid = ($urandom_range(0, 7) == 0);
        rom.rom_data  = 8'($urandom);
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          rom.rom_valid = 1'b1;
          rom.rom_data  = mem[rom.rom_addr];
        end else begin
          cnt--;
          rom.rom_valid = 1'b0;
          rom.rom_data  = 8'($urandom);
        end
      end
    end
  end

  // Core: picks jump flags per instruction (and predicts the next PC), raises exec_done at random.
  initial begin : core_model
    bit         in_instr, prev_ov, jop_i, jc_i;
    logic [7:0] npc;
    in_instr = 1'b0;
    prev_ov  = 1'b0;
    jop_i    = 1'b0;
    jc_i     = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        in_instr = 1'b0;
        prev_ov  = 1'b0;
        exec_done = 1'b0;
        jump_operation = 1'b0;
        jump_condition = 1'b0;
      end else begin
        if (opcode_valid && !prev_ov) begin
          if (force_q.size() > 0) begin
            {jop_i, jc_i} = force_q.pop_front();
          end else begin
            jop_i = ($urandom_range(0, 2) == 0);
            jc_i  = 1'($urandom_range(0, 1));
          end
          if (jop_i && jc_i) npc = m_rec.operand;
          else               npc = m_rec.pc + 8'd1 + {7'd0, m_rec.has};
          m_rec = mk_rec(npc);
          exp_q.push_back(m_rec);
          in_instr = 1'b1;
        end else if (!opcode_valid) begin
          in_instr = 1'b0;
        end
        prev_ov = opcode_valid;
        exec_done = in_instr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
        if (exec_done && in_instr) begin
          jump_operation = jop_i;
          jump_condition = jc_i;
        end else begin
          jump_operation = 1'($urandom_range(0, 1));
          jump_condition = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pops the expected instruction when an opcode is presented and checks the bus around it.
  initial begin : monitor
    bit         p_ov, p_opv, p_rd, p_vld, have_cur;
    logic [7:0] p_addr, a1;
    rec_t       cur;
    int         since_ov;
    p_ov = 1'b0; p_opv = 1'b0; p_rd = 1'b0; p_vld = 1'b0; have_cur = 1'b0;
    p_addr = 8'h00;
    since_ov = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ov = 1'b0; p_opv = 1'b0; p_rd = 1'b0; p_vld = 1'b0; have_cur = 1'b0;
        since_ov = 0;
        continue;
      end
      since_ov++;
      if (opcode_valid && !p_ov) begin
        check("opcode_latency", {30'd0, p_rd, p_vld}, 3);
        if (exp_q.size() == 0) begin
          check("expect_queue_empty", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          $display("instr pc=%02h opcode=%02h two_byte=%0d", pc, opcode, cur.has);
          check("pc", pc, cur.pc);
          check("opcode", opcode, cur.opcode);
        end
`ifndef IFETCH_HALT_EN
        check("halted", halted, 0);
`endif
        n_instr++;
        since_ov = 0;
      end
      if (have_cur) begin
        if (opcode_valid && p_ov) check("opcode_hold", opcode, cur.opcode);
        if (operand_valid && !p_opv) begin
          check("operand_fetch", 1, cur.has);
          check("operand", operand, cur.operand);
        end
        if (operand_valid && p_opv) check("operand_hold", operand, cur.operand);
        if (!opcode_valid && p_ov) begin
          check("retire_operand_valid", p_opv, cur.has);
          check("refetch_latency", rom.rom_rd, 1);
        end
      end
      if (rom.rom_rd && !p_rd) begin
        if (!opcode_valid) begin
          if (exp_q.size() > 0) check("fetch_addr", rom.rom_addr, exp_q[0].pc);
          else                  check("fetch_addr_no_expect", 1, 0);
        end else begin
          a1 = cur.pc + 8'd1;
          check("arg_addr", rom.rom_addr, a1);
          check("arg_latency", since_ov, 2);
        end
      end
      if (rom.rom_rd && p_rd) check("addr_hold", rom.rom_addr, p_addr);
      p_ov = opcode_valid;
      p_opv = operand_valid;
      p_rd = rom.rom_rd;
      p_vld = rom.rom_valid;
      p_addr = rom.rom_addr;
    end
  end

  initial begin : main
    int cyc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      needs_tbl[i] = 1'($urandom_range(0, 1));
    end
    // Directed opening: jump to 8'hFF, wrap the operand fetch to 0, then run opcode 8'hFF at pc 1.
    mem[8'h10] = 8'h40;
    mem[8'h11] = 8'hFF;
    mem[8'hFF] = 8'h41;
    mem[8'h00] = 8'h9A;
    mem[8'h01] = 8'hFF;
    mem[8'h02] = 8'h21;
    needs_tbl[8'h40] = 1'b1;
    needs_tbl[8'h41] = 1'b1;
    needs_tbl[8'hFF] = 1'b0;
    needs_tbl[8'h21] = 1'b0;
    force_q.push_back(2'b11);
    force_q.push_back(2'b10);
    force_q.push_back(2'b00);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_reset("por");
    restart_model();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

`ifdef IFETCH_HALT_EN
    cyc = 0;
    while (!halted && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #3;
    check("halt_reached", halted, 1);
    check("halt_pc", pc, 8'h01);
    check("halt_opcode", opcode, 8'hFF);
    check("halt_opcode_valid", opcode_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_rom_rd", rom.rom_rd, 0);
      check("halt_hold_pc", pc, 8'h01);
    end
`else
    wait_instr(250);
    // Reset while an opcode read is outstanding.
    cyc = 0;
    do begin
      @(posedge clk);
      #3;
      cyc++;
    end while (!(rom.rom_rd && !opcode_valid) && cyc < 2000);
    check("mid_reset_in_wait_op", {31'd0, rom.rom_rd && !opcode_valid}, 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    restart_model();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_instr(n_instr + 150);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
